mpu_load_sequencer: RTL and testbench

Front-end stage of the MPU LOAD path. Accepts one matrix (up to 3x3 single-precision elements) from the MPU bus interface and writes it into the matrix register file one element per cycle, in row-major order, to the selected destination register. It arbitrates for the register-file write port with a request/grant handshake and reports completion or dimension errors back to the bus side.

---
 rtl/mpu_load_sequencer.sv | 154 +++++++++++++++
 tb/tb_mpu_load_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mpu_load_sequencer.sv
// MPU LOAD front end: captures one matrix and streams it row-major into the register file,
// one element per cycle after the write-port grant; all outputs are registered.
module mpu_load_sequencer #(
    parameter int M                = 3,
    parameter int N                = 3,
    parameter int FP               = 32,
    parameter int MATRIX_REGISTERS = 8,
    localparam int MBITS = $clog2(M + 1),
    localparam int NBITS = $clog2(N + 1),
    localparam int ABITS = $clog2(MATRIX_REGISTERS),
    localparam int NE    = M * N,
    localparam int KBITS = $clog2(NE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_req_in,
    output logic                 load_ready_out,
    input  logic [NE*FP-1:0]     matrix_in,
    input  logic [MBITS-1:0]     m_in,
    input  logic [NBITS-1:0]     n_in,
    input  logic [ABITS-1:0]     dest_addr_in,
    output logic                 reg_req_out,
    input  logic                 reg_grant_in,
    output logic                 reg_wr_en_out,
    output logic [ABITS-1:0]     reg_wr_addr_out,
    output logic [MBITS-1:0]     reg_wr_row_out,
    output logic [NBITS-1:0]     reg_wr_col_out,
    output logic [FP-1:0]        reg_wr_data_out,
    output logic                 reg_dim_wr_out,
    output logic [MBITS-1:0]     reg_m_out,
    output logic [NBITS-1:0]     reg_n_out,
    output logic                 load_done_out,
    output logic                 load_error_out
);

    typedef enum logic [1:0] {LOAD_IDLE, LOAD_REQUEST, LOAD_MATRIX} load_state_e;

    load_state_e                state, state_d;
    logic [0:NE-1][FP-1:0]      cap, cap_d;
    logic [MBITS-1:0]           m_q, m_d, row, row_d;
    logic [NBITS-1:0]           n_q, n_d, col, col_d;
    logic [ABITS-1:0]           addr_q, addr_d;
    logic [KBITS-1:0]           k, k_d;
    logic                       wr_en_d, dim_wr_d, done_d, error_d;
    logic                       bad_dims, last;

    assign reg_m_out = m_q;
    assign reg_n_out = n_q;

    always_comb begin
        state_d  = state;
        cap_d    = cap;
        m_d      = m_q;
        n_d      = n_q;
        addr_d   = addr_q;
        row_d    = row;
        col_d    = col;
        k_d      = k;
        wr_en_d  = 1'b0;
        dim_wr_d = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b0;

        bad_dims = (m_in == '0) || (n_in == '0) ||
                   (8'(m_in) > 8'(M)) || (8'(n_in) > 8'(N));
        // row/col track the element currently on the write outputs
        last     = (row == MBITS'(m_q - 1'b1)) && (col == NBITS'(n_q - 1'b1));

        case (state)
            LOAD_IDLE: begin
                if (load_req_in) begin
                    if (bad_dims) begin
                        error_d = 1'b1;
                    end else begin
                        cap_d   = matrix_in;
                        m_d     = m_in;
                        n_d     = n_in;
                        addr_d  = dest_addr_in;
                        row_d   = '0;
                        col_d   = '0;
                        k_d     = '0;
                        state_d = LOAD_REQUEST;
                    end
                end
            end
            LOAD_REQUEST: begin
                if (reg_grant_in) begin
                    state_d  = LOAD_MATRIX;
                    wr_en_d  = 1'b1;
                    dim_wr_d = 1'b1;
                end
            end
            LOAD_MATRIX: begin
                if (last) begin
                    state_d = LOAD_IDLE;
                    done_d  = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                    k_d     = k + 1'b1;
                    if (col == NBITS'(n_q - 1'b1)) begin
                        col_d = '0;
                        row_d = row + 1'b1;
                    end else begin
                        col_d = col + 1'b1;
                    end
                end
            end
            default: state_d = LOAD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= LOAD_IDLE;
            cap             <= '0;
            m_q             <= '0;
            n_q             <= '0;
            addr_q          <= '0;
            row             <= '0;
            col             <= '0;
            k               <= '0;
            load_ready_out  <= 1'b1;
            reg_req_out     <= 1'b0;
            reg_wr_en_out   <= 1'b0;
            reg_wr_addr_out <= '0;
            reg_wr_row_out  <= '0;
            reg_wr_col_out  <= '0;
            reg_wr_data_out <= '0;
            reg_dim_wr_out  <= 1'b0;
            load_done_out   <= 1'b0;
            load_error_out  <= 1'b0;
        end else begin
            state           <= state_d;
            cap             <= cap_d;
            m_q             <= m_d;
            n_q             <= n_d;
            addr_q          <= addr_d;
            row             <= row_d;
            col             <= col_d;
            k               <= k_d;
            load_ready_out  <= (state_d == LOAD_IDLE);
            reg_req_out     <= (state_d != LOAD_IDLE);
            reg_wr_en_out   <= wr_en_d;
            reg_wr_addr_out <= wr_en_d ? addr_d : '0;
            reg_wr_row_out  <= wr_en_d ? row_d : '0;
            reg_wr_col_out  <= wr_en_d ? col_d : '0;
            reg_wr_data_out <= wr_en_d ? cap_d[k_d] : '0;
            reg_dim_wr_out  <= dim_wr_d;
            load_done_out   <= done_d;
            load_error_out  <= error_d;
        end
    end

endmodule

// File: tb/tb_mpu_load_sequencer.sv
// Directed bench for mpu_load_sequencer: table of load scenarios plus abort and back-to-back sequences.
`timescale 1ns/1ps
module tb_mpu_load_sequencer;
    localparam int FP = 32;
    localparam int NE = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_req_in, load_ready_out;
    logic [NE*FP-1:0] matrix_in;
    logic [1:0]      m_in, n_in;
    logic [2:0]      dest_addr_in;
    logic            reg_req_out, reg_grant_in, reg_wr_en_out;
    logic [2:0]      reg_wr_addr_out;
    logic [1:0]      reg_wr_row_out, reg_wr_col_out;
    logic [FP-1:0]   reg_wr_data_out;
    logic            reg_dim_wr_out;
    logic [1:0]      reg_m_out, reg_n_out;
    logic            load_done_out, load_error_out;

    mpu_load_sequencer dut (
        .clk(clk), .rst(rst),
        .load_req_in(load_req_in), .load_ready_out(load_ready_out),
        .matrix_in(matrix_in), .m_in(m_in), .n_in(n_in), .dest_addr_in(dest_addr_in),
        .reg_req_out(reg_req_out), .reg_grant_in(reg_grant_in),
        .reg_wr_en_out(reg_wr_en_out), .reg_wr_addr_out(reg_wr_addr_out),
        .reg_wr_row_out(reg_wr_row_out), .reg_wr_col_out(reg_wr_col_out),
        .reg_wr_data_out(reg_wr_data_out), .reg_dim_wr_out(reg_dim_wr_out),
        .reg_m_out(reg_m_out), .reg_n_out(reg_n_out),
        .load_done_out(load_done_out), .load_error_out(load_error_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    localparam logic [NE*FP-1:0] FMAT = {32'h3f800000, 32'h40000000, 32'h40400000,
                                         32'h40800000, 32'h40a00000, 32'h40c00000,
                                         32'h40e00000, 32'h41000000, 32'h41100000};
    localparam logic [NE*FP-1:0] BMAT = {32'hc0000000, 32'h3f000000, 32'h40490fdb,
                                         32'h42c80000, 160'h0};
    localparam logic [NE*FP-1:0] CMAT = {9{32'hdeadbeef}};
    localparam logic [NE*FP-1:0] NMAT = {32'hbf800000, 256'h0};

    typedef struct {
        int m;
        int n;
        int dest;
        int gd;
        bit err;
        int exp_done;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FP-1:0] elem(input logic [NE*FP-1:0] mat, input int k);
        return mat[(NE-1-k)*FP +: FP];
    endfunction

    task automatic check_idle_reset(input string tag);
        check({tag, ".ready"}, 64'(load_ready_out), 64'(1));
        check({tag, ".outs"}, 64'({reg_req_out, reg_wr_en_out, reg_wr_addr_out, reg_wr_row_out,
                                   reg_wr_col_out, reg_dim_wr_out, reg_m_out, reg_n_out,
                                   load_done_out, load_error_out}), 64'(0));
        check({tag, ".data"}, 64'(reg_wr_data_out), 64'(0));
    endtask

    // Called at a negedge with the sequencer ready; the request is accepted at the next posedge.
    task automatic do_load(input int m, input int n, input int dest, input int gd, input int exp_done,
                           input logic [NE*FP-1:0] mat, input logic [NE*FP-1:0] nmat,
                           input int nm, input int nn, input int abort_at, input bit keep_req);
        int nw;
        bit fin;
        load_req_in  = 1'b1;
        matrix_in    = mat;
        m_in         = 2'(m);
        n_in         = 2'(n);
        dest_addr_in = 3'(dest);
        reg_grant_in = (gd == 0);
        @(posedge clk);
        @(negedge clk);
        if (!keep_req) load_req_in = 1'b0;
        matrix_in    = nmat;
        m_in         = 2'(nm);
        n_in         = 2'(nn);
        dest_addr_in = 3'(dest + 1);
        nw  = 0;
        fin = 1'b0;
        for (int t = 1; t <= 40 && !fin; t++) begin
            if (t == gd + 1) reg_grant_in = 1'b1;
            if (t >= gd + 2 && t < exp_done) begin
                int k;
                k = t - gd - 2;
                check("wr_en", 64'(reg_wr_en_out), 64'(1));
                check("wr_addr", 64'(reg_wr_addr_out), 64'(dest));
                check("wr_row", 64'(reg_wr_row_out), 64'(k / n));
                check("wr_col", 64'(reg_wr_col_out), 64'(k % n));
                check("wr_data", 64'(reg_wr_data_out), 64'(elem(mat, k)));
                check("dim_wr", 64'(reg_dim_wr_out), 64'(k == 0));
                if (k == 0) begin
                    check("m_out", 64'(reg_m_out), 64'(m));
                    check("n_out", 64'(reg_n_out), 64'(n));
                end
                nw++;
            end else begin
                check("wr_en_quiet", 64'(reg_wr_en_out), 64'(0));
            end
            if (t < exp_done) begin
                check("busy_req_ready_done", 64'({reg_req_out, load_ready_out, load_done_out}), 64'(3'b100));
            end else begin
                check("done_req_ready", 64'({load_done_out, reg_req_out, load_ready_out}), 64'(3'b101));
                fin = 1'b1;
            end
            if (!fin && abort_at > 0 && nw == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_idle_reset("abort");
                rst = 1'b0;
                @(negedge clk);
                check("post_abort_quiet", 64'({reg_wr_en_out, reg_req_out, load_ready_out}), 64'(3'b001));
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL load_timeout: no done within 40 cycles, m=%0d n=%0d", m, n);
        end
    endtask

    task automatic do_err(input int m, input int n);
        load_req_in  = 1'b1;
        matrix_in    = CMAT;
        m_in         = 2'(m);
        n_in         = 2'(n);
        dest_addr_in = 3'd6;
        reg_grant_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_req_in = 1'b0;
        check("err_pulse", 64'({load_error_out, load_ready_out, reg_req_out, reg_wr_en_out}), 64'(4'b1100));
        @(negedge clk);
        check("err_after", 64'({load_error_out, load_ready_out, reg_req_out, reg_wr_en_out}), 64'(4'b0100));
        @(negedge clk);
        check("err_settled", 64'({load_error_out, load_ready_out, reg_req_out, reg_wr_en_out}), 64'(4'b0100));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{m: 3, n: 3, dest: 2, gd: 0, err: 1'b0, exp_done: 11};
        vecs[1] = '{m: 2, n: 3, dest: 5, gd: 4, err: 1'b0, exp_done: 12};
        vecs[2] = '{m: 0, n: 2, dest: 0, gd: 0, err: 1'b1, exp_done: 0};
        vecs[3] = '{m: 2, n: 0, dest: 0, gd: 0, err: 1'b1, exp_done: 0};
        vecs[4] = '{m: 1, n: 3, dest: 7, gd: 1, err: 1'b0, exp_done: 6};
        vecs[5] = '{m: 3, n: 1, dest: 0, gd: 0, err: 1'b0, exp_done: 5};
        vecs[6] = '{m: 0, n: 0, dest: 0, gd: 0, err: 1'b1, exp_done: 0};

        rst          = 1'b1;
        load_req_in  = 1'b0;
        matrix_in    = '0;
        m_in         = '0;
        n_in         = '0;
        dest_addr_in = '0;
        reg_grant_in = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_reset("idle");

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].err) do_err(vecs[i].m, vecs[i].n);
            else do_load(vecs[i].m, vecs[i].n, vecs[i].dest, vecs[i].gd, vecs[i].exp_done,
                         FMAT, CMAT, 3, 3, 0, 1'b0);
        end

        // reset after the 4th write, then a 1x1 load of -1.0
        do_load(3, 3, 2, 0, 11, FMAT, CMAT, 3, 3, 4, 1'b0);
        do_load(1, 1, 1, 0, 3, NMAT, CMAT, 3, 3, 0, 1'b0);

        // request held high across two 2x2 loads; live bus differs from captured data
        do_load(2, 2, 3, 0, 6, FMAT, BMAT, 2, 2, 0, 1'b1);
        do_load(2, 2, 4, 0, 6, BMAT, CMAT, 3, 3, 0, 1'b0);
        @(negedge clk);
        check("final_idle", 64'({load_ready_out, reg_req_out, reg_wr_en_out}), 64'(3'b100));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
